// File: rtl/prng_pkg.sv
// Shared constants, mode encoding and seed helpers for the Gaussian/uniform PRNG.
package prng_pkg;
  localparam logic [7:0] DEF_TAPS        = 8'h8E;
  localparam logic [7:0] DEF_SEED_BASE   = 8'hBD;
  localparam logic [7:0] DEF_SEED_STRIDE = 8'h5B;

  typedef enum logic {
    MODE_UNIFORM = 1'b0,
    MODE_GAUSS   = 1'b1
  } mode_e;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (64'd1 << r) < 64'(v); r++) begin
    end
    return r;
  endfunction

  // Lane k seed = base ^ (k*stride) truncated to w bits; zero is never a legal seed.
  function automatic logic [63:0] derive_seed(input logic [63:0] base,
                                              input logic [63:0] stride,
                                              input int k, input int w);
    logic [63:0] mask, s;
    mask = ~64'd0 >> (64 - w);
    s    = (base ^ (stride * 64'(k))) & mask;
    if (s == 64'd0) s = 64'd1;
    return s;
  endfunction
endpackage

// File: rtl/galois_lfsr_lane.sv
// One Galois LFSR lane with load and stall; zero-state repair when PRNG_LOCKUP_GUARD_EN is defined.
module galois_lfsr_lane
  import prng_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             step,
  output logic [WIDTH-1:0] state,
  output logic             zero_fix
);
  logic [WIDTH-1:0] state_q, nxt;

  assign nxt   = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
  assign state = state_q;

`ifdef PRNG_LOCKUP_GUARD_EN
  assign zero_fix = (state_q == '0);
`else
  assign zero_fix = 1'b0;
`endif

  // Repair outranks stepping so a stalled lane still escapes the zero state.
  always_ff @(posedge clk) begin
    if (rst)           state_q <= RST_SEED;
    else if (load)     state_q <= load_value;
    else if (zero_fix) state_q <= WIDTH'(1);
    else if (step)     state_q <= nxt;
  end
endmodule

// File: rtl/prng_gauss_gen.sv
// Multi-lane Galois PRNG: uniform (lane 0 raw) or binomial sum of lane popcounts, 2-stage stallable output.
// Lockup repair and sticky lockup flag exist only when PRNG_LOCKUP_GUARD_EN is defined.
module prng_gauss_gen
  import prng_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               CHANNELS    = 8,
  parameter logic [WIDTH-1:0] TAPS        = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED_BASE   = WIDTH'(DEF_SEED_BASE),
  parameter logic [WIDTH-1:0] SEED_STRIDE = WIDTH'(DEF_SEED_STRIDE),
  localparam int SUM_W = clog2(CHANNELS*WIDTH + 1),
  localparam int OUT_W = (WIDTH > SUM_W) ? WIDTH : SUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_value,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lockup
);
  localparam int PW = clog2(WIDTH + 1);

  logic [CHANNELS-1:0][WIDTH-1:0] lane_state;
  logic [CHANNELS-1:0][WIDTH-1:0] lane_seed;
  logic [CHANNELS-1:0][PW-1:0]    lane_pop;
  logic [CHANNELS-1:0]            lane_fix;

  logic                        adv, step;
  logic [WIDTH-1:0]            s1_raw;
  logic [CHANNELS-1:0][PW-1:0] s1_pop;
  mode_e                       s1_mode;
  logic                        v1;
  logic [OUT_W-1:0]            pop_sum;

  assign adv  = !out_valid || out_ready;
  assign step = adv && !seed_load;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    localparam logic [WIDTH-1:0] RST_SEED =
      WIDTH'(derive_seed(64'(SEED_BASE), 64'(SEED_STRIDE), k, WIDTH));

    assign lane_seed[k] = WIDTH'(derive_seed(64'(seed_value), 64'(SEED_STRIDE), k, WIDTH));

    galois_lfsr_lane #(
      .WIDTH    (WIDTH),
      .TAPS     (TAPS),
      .RST_SEED (RST_SEED)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .load       (seed_load),
      .load_value (lane_seed[k]),
      .step       (step),
      .state      (lane_state[k]),
      .zero_fix   (lane_fix[k])
    );

    always_comb begin
      lane_pop[k] = '0;
      for (int i = 0; i < WIDTH; i++) lane_pop[k] = lane_pop[k] + PW'(lane_state[k][i]);
    end
  end

  // Accumulator is OUT_W wide, which covers CHANNELS*WIDTH, so the sum cannot wrap.
  always_comb begin
    pop_sum = '0;
    for (int k = 0; k < CHANNELS; k++) pop_sum = pop_sum + OUT_W'(s1_pop[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      s1_raw    <= '0;
      s1_pop    <= '0;
      s1_mode   <= MODE_UNIFORM;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (seed_load) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      v1        <= 1'b1;
      s1_raw    <= lane_state[0];
      s1_pop    <= lane_pop;
      s1_mode   <= mode_e'(mode);
      out_valid <= v1;
      out_data  <= (s1_mode == MODE_GAUSS) ? pop_sum : OUT_W'(s1_raw);
    end
  end

  // lane_fix is constant 0 without the guard, so this collapses to a tied-off flag.
  always_ff @(posedge clk) begin
    if (rst || seed_load) lockup <= 1'b0;
    else if (|lane_fix)   lockup <= 1'b1;
  end
endmodule

// File: tb/tb_prng_gauss_gen.sv
// Directed self-checking bench for prng_gauss_gen (defaults plus a single-lane instance).
module tb_prng_gauss_gen;
  logic       clk = 1'b0;
  logic       rst, mode, seed_load, out_ready;
  logic [7:0] seed_value;
  logic [7:0] out_data;
  logic       out_valid, lockup;

  logic       mode1, seed_load1;
  logic [7:0] out_data1;
  logic       out_valid1, lockup1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prng_gauss_gen dut (
    .clk(clk), .rst(rst), .mode(mode), .seed_load(seed_load), .seed_value(seed_value),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .lockup(lockup)
  );

  prng_gauss_gen #(.CHANNELS(1)) dut1 (
    .clk(clk), .rst(rst), .mode(mode1), .seed_load(seed_load1), .seed_value(seed_value),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(1'b1), .lockup(lockup1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_u [4];
    logic [7:0] exp_g1 [3];
    int gaps, oob;
    longint sum;
    exp_u  = '{8'hBD, 8'hD0, 8'h68, 8'h34};
    exp_g1 = '{8'd6, 8'd3, 8'd3};

    rst = 1'b1; mode = 1'b0; seed_load = 1'b0; seed_value = 8'h00; out_ready = 1'b1;
    mode1 = 1'b1; seed_load1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_lockup", lockup, 0);
    chk("rst_valid1", out_valid1, 0);

    // First sample after reset arrives on the second edge.
    rst = 1'b0;
    @(negedge clk);
    chk("lat_valid", out_valid, 0);
    chk("lat_valid1", out_valid1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("uni_valid%0d", i), out_valid, 1);
      chk($sformatf("uni_data%0d", i), out_data, exp_u[i]);
      if (i < 3) chk($sformatf("gauss1_data%0d", i), out_data1, exp_g1[i]);
    end

    // Stall on the first sample.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_first", out_data, 8'hBD);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_valid%0d", i), out_valid, 1);
      chk($sformatf("stall_hold%0d", i), out_data, 8'hBD);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_next", out_data, 8'hD0);

    // Reseed mid-stream flushes the pipe.
    seed_value = 8'h01; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    chk("seed_flush0", out_valid, 0);
    @(negedge clk);
    chk("seed_flush1", out_valid, 0);
    @(negedge clk);
    chk("seed_valid", out_valid, 1);
    chk("seed_data0", out_data, 8'h01);
    @(negedge clk);
    chk("seed_data1", out_data, 8'h8E);

    // The sample already in stage 1 keeps uniform mode.
    mode = 1'b1;
    @(negedge clk);
    chk("mode_keep", out_data, 8'h47);

    // Gaussian statistics.
    seed_value = 8'hBD; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    repeat (2) @(negedge clk);
    gaps = 0; oob = 0; sum = 0;
    for (int i = 0; i < 4096; i++) begin
      if (!out_valid) gaps++;
      if (out_data > 8'd64) oob++;
      sum += longint'(out_data);
      @(negedge clk);
    end
    chk("gauss_gaps", gaps, 0);
    chk("gauss_range", oob, 0);
    chk("gauss_mean", (sum >= 31*4096 && sum <= 33*4096) ? 1 : 0, 1);

    // Zero-state behaviour on lane 0.
    mode = 1'b0;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_lockup", lockup, 0);
    chk("pre_zero_data", out_data, 8'hBD);
    force dut.g_lane[0].u_lane.state_q = 8'h00;
    #1;
    release dut.g_lane[0].u_lane.state_q;
`ifdef PRNG_LOCKUP_GUARD_EN
    @(negedge clk);
    chk("guard_fix", dut.g_lane[0].u_lane.state_q, 1);
    chk("guard_lockup", lockup, 1);
    @(negedge clk);
    chk("guard_sticky", lockup, 1);
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    chk("guard_clear", lockup, 0);
`else
    repeat (3) @(negedge clk);
    chk("zero_data0", out_data, 0);
    chk("zero_lockup", lockup, 0);
    @(negedge clk);
    chk("zero_data1", out_data, 0);
    chk("zero_lockup1", lockup, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prng_gauss_gen.md
Name: prng_gauss_gen

Overview:
- Parametrised successor of the team's 8-bit Galois LFSR and 8-lane Gaussian sum generator.
- Contains CHANNELS independent Galois LFSRs of WIDTH bits, with configurable taps, runtime reseed and a runtime mode select.
- Mode 0 (uniform) outputs the raw channel-0 state. Mode 1 (Gaussian) outputs the sum of all channel popcounts, i.e. a binomial approximation of a normal distribution.
- Output uses a stallable valid/ready handshake. Feeds game-logic consumers (spawn jitter, noise).

Parameters:
- WIDTH, 8, LFSR width in bits (>=3).
- CHANNELS, 8, number of LFSR lanes (>=1).
- TAPS, 8'h8E, Galois feedback mask, WIDTH bits wide. Default reproduces the existing 8-bit sequence.
- SEED_BASE, 8'hBD, reset seed for channel 0, WIDTH bits wide.
- SEED_STRIDE, 8'h5B, per-channel seed offset, WIDTH bits wide.
- Derived localparam OUT_W = max(WIDTH, clog2(CHANNELS*WIDTH+1)). Defaults give OUT_W = 8.

Ports:
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- mode, in, 1: 0 = uniform, 1 = Gaussian. Sampled per sample.
- seed_load, in, 1: reseed strobe.
- seed_value, in, WIDTH: base seed used with seed_load.
- out_data, out, OUT_W: sample value.
- out_valid, out, 1: out_data holds a sample.
- out_ready, in, 1: consumer accepts the sample.
- lockup, out, 1: sticky flag, set when the guard repaired a zero state.

Behaviour:
- Step function for each channel: next = (s >> 1) ^ (s[0] ? TAPS : 0).
- Seed derivation: seed_k = base ^ (k*SEED_STRIDE mod 2^WIDTH). If seed_k == 0, it is replaced by 1. base is SEED_BASE on reset and seed_value on seed_load.
- Reset (rst=1): every LFSR loads seed_k; stage-1 valid, out_valid, out_data and lockup clear to 0.
- Advance condition: adv = !out_valid || out_ready.
- Stage 1 registers, captured when adv=1:
  - s1_raw = channel-0 state.
  - s1_pop[k] = popcount(channel k).
  - s1_mode = mode.
  - v1 = 1.
  - All LFSRs step in the same cycle.
- Stage 1 when adv=0: everything holds, LFSRs do not step.
- Stage 2 / output, captured when adv=1:
  - out_data = s1_mode ? sum(s1_pop) : zero-extend(s1_raw).
  - out_valid = v1.
- Latency: first sample is valid on the 2nd clock edge after rst falls, and reflects the seed states. Thereafter one sample per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, out_data is held stable. No LFSR steps, no sample is lost or duplicated.
- Gaussian mode range is 0..CHANNELS*WIDTH with mean CHANNELS*WIDTH/2 (defaults: 0..64, mean 32). The adder is full width, so it never wraps.
- Priority: rst > seed_load > step.
- seed_load=1 (when rst=0):
  - All LFSRs load derived seeds from seed_value.
  - v1 and out_valid clear next cycle, flushing in-flight samples.
  - Next valid sample appears 2 cycles after seed_load falls.
  - Holding seed_load high keeps reloading and out_valid stays 0.
- Mode change: takes effect on the next sample captured into stage 1. The sample already in stage 1 keeps its mode.
- Reset mid-stall: discards the held sample; out_valid=0 next cycle.

Optional Feature:
- Macro: PRNG_LOCKUP_GUARD_EN.
- Defined:
  - Each channel is checked every cycle. If its state == 0 (SEU or forced), it is overwritten with 1 on the next edge instead of stepping.
  - lockup sets and stays set until rst or seed_load.
- Undefined: no check; lockup tied to 0. A zero state persists and produces zeros forever.

Decomposition:
- Package prng_pkg holds:
  - default TAPS/SEED constants;
  - a clog2 function;
  - the seed-derivation function;
  - the mode enum (MODE_UNIFORM = 0, MODE_GAUSS = 1).
- Sub-module galois_lfsr_lane, parametrised WIDTH/TAPS. Ports: clk, rst, load, load_value, step, state, zero_fix. Instantiated CHANNELS times via generate.
- Popcount and adder tree stay in the top module.

Test Plan:
- Defaults, mode=0, out_ready=1, release rst -> out_data sequence 0xBD, 0xD0, 0x68, 0x34, with out_valid high from the 2nd edge.
- CHANNELS=1, mode=1, out_ready=1 -> out_data 6, 3, 3 (popcounts of 0xBD, 0xD0, 0x68).
- Defaults, mode=0, drop out_ready for 5 cycles after the first sample -> 0xBD held for 5 cycles; next accepted sample is 0xD0 (no skip).
- seed_load=1 with seed_value=8'h01 for 1 cycle mid-stream -> out_valid=0 for 2 cycles; then channel-0 sample 0x01 followed by 0x8E.
- Defaults, mode=1 for 4096 samples -> every value in 0..64, mean within 32±1, no out_valid gaps with out_ready=1.
- With PRNG_LOCKUP_GUARD_EN, force channel 0 state to 0 -> state becomes 1 next cycle and lockup=1 until seed_load. Without the macro -> channel-0 raw samples stay 0 and lockup=0.
